// File: rtl/coin_pkg.sv
// Shared definitions for the coin collector: coin codes, field sizing,
// FSM state encoding and the helper that packs the three counts.
package coin_pkg;

    localparam int CNT_W     = 3;
    localparam int FIELD_MAX = 7;
    localparam int VEC_W     = 3 * CNT_W;

    localparam logic [1:0] COIN_A       = 2'd0;
    localparam logic [1:0] COIN_B       = 2'd1;
    localparam logic [1:0] COIN_C       = 2'd2;
    localparam logic [1:0] COIN_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EVAL    = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    // Field order matches what the decision block expects: C high, A low.
    function automatic logic [VEC_W-1:0] pack_counts(input logic [CNT_W-1:0] cnt_a,
                                                     input logic [CNT_W-1:0] cnt_b,
                                                     input logic [CNT_W-1:0] cnt_c);
        return {cnt_c, cnt_b, cnt_a};
    endfunction

endpackage

// File: rtl/coin_counter_sat.sv
// Saturating per-denomination coin counter with synchronous clear.
// Clear wins over increment; increments at MAX are dropped.
module coin_counter_sat
    import coin_pkg::*;
#(
    parameter int W   = CNT_W,
    parameter int MAX = FIELD_MAX
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         full
);

    assign full = (count == W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/coin_collector.sv
// Coin collection front end for the vending decision block.
// Optional feature: define COIN_TIMEOUT_EN to auto-refund after TIMEOUT_CYCLES idle cycles in COLLECT.
module coin_collector
   import coin_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             coin_valid,
   input  logic [1:0]       coin_type,
   input  logic             buy,
   input  logic             cancel,
   input  logic             conclusion,
   input  logic [3:0]       remcach,
   output logic [VEC_W-1:0] clientcoin,
   output logic             coin_accept,
   output logic             coin_reject,
   output logic             vend,
   output logic [3:0]       change_out,
   output logic             refund,
   output logic [VEC_W-1:0] refund_vec,
   output logic             busy
);

   state_t state;
   state_t nextState;

   logic [CNT_W-1:0] cntA;
   logic [CNT_W-1:0] cntB;
   logic [CNT_W-1:0] cntC;
   logic             fullA;
   logic             fullB;
   logic             fullC;
   logic [VEC_W-1:0] counts;

   logic legal;
   logic openForCoins;
   logic selFull;
   logic take;
   logic incA;
   logic incB;
   logic incC;
   logic clr;
   logic timeout;
   logic settleVend;

   coin_counter_sat #(.W(CNT_W), .MAX(FIELD_MAX)) u_cnt_a (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (incA),
      .clr   (clr),
      .count (cntA),
      .full  (fullA)
   );

   coin_counter_sat #(.W(CNT_W), .MAX(FIELD_MAX)) u_cnt_b (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (incB),
      .clr   (clr),
      .count (cntB),
      .full  (fullB)
   );

   coin_counter_sat #(.W(CNT_W), .MAX(FIELD_MAX)) u_cnt_c (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (incC),
      .clr   (clr),
      .count (cntC),
      .full  (fullC)
   );

   assign counts = pack_counts(cntA, cntB, cntC);
   assign clr    = (state == ST_SETTLE);

   // A coin is taken only while collecting and only if its field has room.
   always_comb begin
      legal        = coin_valid && (coin_type != COIN_ILLEGAL);
      openForCoins = (state == ST_IDLE) || (state == ST_COLLECT);
      selFull      = 1'b1;
      case (coin_type)
         COIN_A:  selFull = fullA;
         COIN_B:  selFull = fullB;
         COIN_C:  selFull = fullC;
         default: selFull = 1'b1;
      endcase
      take = legal && openForCoins && !selFull;
      incA = take && (coin_type == COIN_A);
      incB = take && (coin_type == COIN_B);
      incC = take && (coin_type == COIN_C);
   end

`ifdef COIN_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] idleCnt;
   logic            activity;

   assign activity = coin_valid || buy || cancel;
   assign timeout  = (state == ST_COLLECT) && !activity &&
                     (idleCnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Idle counter runs only in COLLECT and restarts on any activity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idleCnt <= '0;
      end else if ((state == ST_COLLECT) && !activity) begin
         idleCnt <= idleCnt + TO_W'(1);
      end else begin
         idleCnt <= '0;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // State register with asynchronous reset to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Cancel outranks buy; both are only honoured once coins are held.
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE: begin
            if (take) begin
               nextState = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (cancel) begin
               nextState = ST_SETTLE;
            end else if (buy) begin
               nextState = ST_EVAL;
            end else if (timeout) begin
               nextState = ST_SETTLE;
            end
         end
         ST_EVAL:   nextState = ST_SETTLE;
         ST_SETTLE: nextState = ST_IDLE;
         default:   nextState = ST_IDLE;
      endcase
   end

   // settleVend is only set when leaving EVAL with an accepted sale, so
   // SETTLE reached by cancel or timeout always resolves to a refund.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coin_accept <= 1'b0;
         coin_reject <= 1'b0;
         settleVend  <= 1'b0;
         change_out  <= '0;
      end else begin
         coin_accept <= take;
         coin_reject <= coin_valid && !take;
         settleVend  <= (state == ST_EVAL) && conclusion;
         if ((state == ST_EVAL) && conclusion) begin
            change_out <= remcach;
         end
      end
   end

   assign vend       = (state == ST_SETTLE) && settleVend;
   assign refund     = (state == ST_SETTLE) && !settleVend;
   assign refund_vec = refund ? counts : '0;
   assign clientcoin = (state == ST_EVAL) ? counts : '0;
   assign busy       = (state == ST_EVAL) || (state == ST_SETTLE);

endmodule

// File: tb/tb_coin_collector.sv
// Directed self-checking bench for coin_collector; inputs driven and outputs sampled on the falling edge.
// Define COIN_TIMEOUT_EN to also exercise the idle auto-refund with TIMEOUT_CYCLES=10.
module tb_coin_collector;

   logic       clk;
   logic       rst_n;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       buy;
   logic       cancel;
   logic       conclusion;
   logic [3:0] remcach;
   logic [8:0] clientcoin;
   logic       coin_accept;
   logic       coin_reject;
   logic       vend;
   logic [3:0] change_out;
   logic       refund;
   logic [8:0] refund_vec;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   coin_collector #(.TIMEOUT_CYCLES(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .coin_valid  (coin_valid),
      .coin_type   (coin_type),
      .buy         (buy),
      .cancel      (cancel),
      .conclusion  (conclusion),
      .remcach     (remcach),
      .clientcoin  (clientcoin),
      .coin_accept (coin_accept),
      .coin_reject (coin_reject),
      .vend        (vend),
      .change_out  (change_out),
      .refund      (refund),
      .refund_vec  (refund_vec),
      .busy        (busy)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic cv, input logic [1:0] ct,
                                input logic b, input logic c);
      coin_valid = cv;
      coin_type  = ct;
      buy        = b;
      cancel     = c;
   endtask

   task automatic setVmp(input logic c, input logic [3:0] r);
      conclusion = c;
      remcach    = r;
   endtask

   task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Directed test sequence following the specification's testing list.
   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
      setVmp(1'b0, 4'd0);
      #12;
      checkOutput("rst_clientcoin", clientcoin, 9'd0);
      checkOutput("rst_busy", {8'd0, busy}, 9'd0);
      checkOutput("rst_vend", {8'd0, vend}, 9'd0);
      checkOutput("rst_refund", {8'd0, refund}, 9'd0);
      checkOutput("rst_change", {5'd0, change_out}, 9'd0);
      checkOutput("rst_accept", {8'd0, coin_accept}, 9'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: A,B,B,C then buy, sale accepted with change 3
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0); tick();
      checkOutput("t1_acc_a", {8'd0, coin_accept}, 9'd1);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0); tick();
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0); tick();
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b0); tick();
      checkOutput("t1_acc_c", {8'd0, coin_accept}, 9'd1);
      checkOutput("t1_collect_busy", {8'd0, busy}, 9'd0);
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
      setVmp(1'b1, 4'd3);
      tick();
      checkOutput("t1_eval_vec", clientcoin, 9'b001_010_001);
      checkOutput("t1_eval_busy", {8'd0, busy}, 9'd1);
      checkOutput("t1_eval_novend", {8'd0, vend}, 9'd0);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0); tick();
      checkOutput("t1_vend", {8'd0, vend}, 9'd1);
      checkOutput("t1_change", {5'd0, change_out}, 9'd3);
      checkOutput("t1_norefund", {8'd0, refund}, 9'd0);
      checkOutput("t1_settle_vec", clientcoin, 9'd0);
      setVmp(1'b0, 4'd0); tick();
      checkOutput("t1_idle_vend", {8'd0, vend}, 9'd0);
      checkOutput("t1_idle_busy", {8'd0, busy}, 9'd0);
      checkOutput("t1_change_held", {5'd0, change_out}, 9'd3);

      // Test 2: eight A coins saturate the field, sale declined
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 2'd0, 1'b0, 1'b0); tick();
         checkOutput("t2_acc", {8'd0, coin_accept}, {8'd0, (i < 7)});
         checkOutput("t2_rej", {8'd0, coin_reject}, {8'd0, (i == 7)});
      end
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
      setVmp(1'b0, 4'd9);
      tick();
      checkOutput("t2_eval_vec", clientcoin, 9'b000_000_111);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0); tick();
      checkOutput("t2_refund", {8'd0, refund}, 9'd1);
      checkOutput("t2_refund_vec", refund_vec, 9'b000_000_111);
      checkOutput("t2_novend", {8'd0, vend}, 9'd0);
      checkOutput("t2_change_held", {5'd0, change_out}, 9'd3);
      tick();
      checkOutput("t2_idle_refund", {8'd0, refund}, 9'd0);
      checkOutput("t2_idle_vec", refund_vec, 9'd0);

      // Test 3: coin B arrives with buy while holding one A
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0); tick();
      applyStimulus(1'b1, 2'd1, 1'b1, 1'b0); tick();
      checkOutput("t3_acc_b", {8'd0, coin_accept}, 9'd1);
      checkOutput("t3_eval_vec", clientcoin, 9'b000_001_001);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0); tick();
      checkOutput("t3_refund_vec", refund_vec, 9'b000_001_001);
      tick();

      // Test 4: cancel and buy together, cancel wins
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b0); tick();
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b1); tick();
      checkOutput("t4_refund", {8'd0, refund}, 9'd1);
      checkOutput("t4_refund_vec", refund_vec, 9'b001_000_000);
      checkOutput("t4_no_eval", clientcoin, 9'd0);
      checkOutput("t4_busy", {8'd0, busy}, 9'd1);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0); tick();
      checkOutput("t4_idle_busy", {8'd0, busy}, 9'd0);

      // Test 5: illegal coin, buy with nothing held, coin during EVAL
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b0); tick();
      checkOutput("t5_illegal_rej", {8'd0, coin_reject}, 9'd1);
      checkOutput("t5_illegal_acc", {8'd0, coin_accept}, 9'd0);
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0); tick();
      checkOutput("t5_idle_buy_busy", {8'd0, busy}, 9'd0);
      checkOutput("t5_idle_buy_rej", {8'd0, coin_reject}, 9'd0);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0); tick();
      checkOutput("t5_idle_buy_refund", {8'd0, refund}, 9'd0);
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0); tick();
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
      setVmp(1'b1, 4'd5);
      tick();
      checkOutput("t5_eval_vec", clientcoin, 9'b000_000_001);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1); tick();
      checkOutput("t5_eval_coin_rej", {8'd0, coin_reject}, 9'd1);
      checkOutput("t5_vend", {8'd0, vend}, 9'd1);
      checkOutput("t5_change", {5'd0, change_out}, 9'd5);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
      setVmp(1'b0, 4'd0);
      tick();
      checkOutput("t5_idle_busy", {8'd0, busy}, 9'd0);

      // Test 6: reset asserted during EVAL
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b0); tick();
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0); tick();
      checkOutput("t6_eval_vec", clientcoin, 9'b001_000_000);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_vec", clientcoin, 9'd0);
      checkOutput("t6_rst_busy", {8'd0, busy}, 9'd0);
      checkOutput("t6_rst_change", {5'd0, change_out}, 9'd0);
      checkOutput("t6_rst_refund", {8'd0, refund}, 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0); tick();
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0); tick();
      checkOutput("t6_counts_lost", clientcoin, 9'b000_001_000);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0); tick();
      checkOutput("t6_refund_vec", refund_vec, 9'b000_001_000);
      tick();

`ifdef COIN_TIMEOUT_EN
      // Idle timeout with one A held
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0); tick();
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
      repeat (9) tick();
      checkOutput("to_early_refund", {8'd0, refund}, 9'd0);
      checkOutput("to_early_busy", {8'd0, busy}, 9'd0);
      tick();
      checkOutput("to_refund", {8'd0, refund}, 9'd1);
      checkOutput("to_refund_vec", refund_vec, 9'b000_000_001);
      tick();
      checkOutput("to_idle_busy", {8'd0, busy}, 9'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
